// File: rtl/u_ifu.sv
// Instruction fetch unit: issues sequential word fetches on a req/gnt port,
// tracks outstanding requests with a credit scheme, buffers returned
// instructions in an in-order fetch queue and redirects on a hazard flush.
module u_ifu #(
  parameter int unsigned      XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0,
  parameter int unsigned      FQ_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hzf_ifu,
  input  logic            hzs_ifu,
  input  logic [XLEN-1:0] br_tgt,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rsp_vld,
  input  logic [31:0]     imem_rsp_dat,
  output logic            ifu_vld,
  output logic [XLEN-1:0] ifu_pc,
  output logic [31:0]     ifu_ins
);

  // Pointer width into the FQ_DEPTH-entry storage; counters hold 0..FQ_DEPTH.
  localparam int unsigned AW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FQ_DEPTH + 1);
  localparam logic [CW:0] DepthC = (CW + 1)'(FQ_DEPTH);

  // Fetch address of the next request.
  logic [XLEN-1:0] pc_q, pc_d;

  // Occupancy, wanted in-flight requests, in-flight requests to discard.
  logic [CW-1:0] qcnt_q, qcnt_d;
  logic [CW-1:0] infl_q, infl_d;
  logic [CW-1:0] drop_q, drop_d;

  // Fetch queue storage and pointers.
  logic [XLEN-1:0] fq_pc_q  [FQ_DEPTH];
  logic [XLEN-1:0] fq_pc_d  [FQ_DEPTH];
  logic [31:0]     fq_ins_q [FQ_DEPTH];
  logic [31:0]     fq_ins_d [FQ_DEPTH];
  logic [AW-1:0]   qhead_q, qhead_d;
  logic [AW-1:0]   qtail_q, qtail_d;

  // Per-request PC FIFO, one entry per granted request (wanted or dropped).
  logic [XLEN-1:0] pf_q [FQ_DEPTH];
  logic [XLEN-1:0] pf_d [FQ_DEPTH];
  logic [AW-1:0]   pf_rd_q, pf_rd_d;
  logic [AW-1:0]   pf_wr_q, pf_wr_d;

  logic credit_ok;
  logic grant;
  logic rsp_take;
  logic push;
  logic pop;

  // The low target bits are forced to zero on redirect.
  logic unused_br_lsb;
  assign unused_br_lsb = ^br_tgt[1:0];

  // Request issue, response classification and head outputs.
  always_comb begin
    credit_ok = (({1'b0, qcnt_q} + {1'b0, infl_q}) < DepthC) &&
                (({1'b0, infl_q} + {1'b0, drop_q}) < DepthC);
    imem_req  = !rst && !hzf_ifu && credit_ok;
    imem_addr = rst ? RESET_PC : pc_q;
    grant     = imem_req && imem_gnt;
    // A response with nothing outstanding is a protocol error and is ignored.
    rsp_take  = !rst && imem_rsp_vld && ((drop_q != '0) || (infl_q != '0));
    // A response in the flush cycle belongs to the old stream.
    push      = rsp_take && !hzf_ifu && (drop_q == '0);
    ifu_vld   = !rst && (qcnt_q != '0);
    pop       = ifu_vld && !hzs_ifu && !hzf_ifu;
    ifu_pc    = ifu_vld ? fq_pc_q[qhead_q]  : '0;
    ifu_ins   = ifu_vld ? fq_ins_q[qhead_q] : '0;
  end

  // Next-state for fetch PC, credit counters, PC FIFO and fetch queue.
  always_comb begin
    pc_d     = pc_q;
    qcnt_d   = qcnt_q;
    infl_d   = infl_q;
    drop_d   = drop_q;
    qhead_d  = qhead_q;
    qtail_d  = qtail_q;
    pf_rd_d  = pf_rd_q;
    pf_wr_d  = pf_wr_q;
    fq_pc_d  = fq_pc_q;
    fq_ins_d = fq_ins_q;
    pf_d     = pf_q;

    // PC FIFO stays in request order across flushes; dropped entries drain too.
    if (grant) begin
      pf_d[pf_wr_q] = pc_q;
      pf_wr_d       = pf_wr_q + AW'(1);
    end
    if (rsp_take) begin
      pf_rd_d = pf_rd_q + AW'(1);
    end

    if (hzf_ifu) begin
      pc_d    = {br_tgt[XLEN-1:2], 2'b00};
      infl_d  = '0;
      drop_d  = drop_q + infl_q - CW'(rsp_take);
      qcnt_d  = '0;
      qhead_d = '0;
      qtail_d = '0;
    end else begin
      if (grant) begin
        pc_d = pc_q + XLEN'(4);
      end
      infl_d = infl_q + CW'(grant) - CW'(rsp_take && (drop_q == '0));
      drop_d = drop_q - CW'(rsp_take && (drop_q != '0));
      if (push) begin
        fq_pc_d[qtail_q]  = pf_q[pf_rd_q];
        fq_ins_d[qtail_q] = imem_rsp_dat;
        qtail_d           = qtail_q + AW'(1);
      end
      if (pop) begin
        qhead_d = qhead_q + AW'(1);
      end
      qcnt_d = qcnt_q + CW'(push) - CW'(pop);
    end
  end

  // State registers with synchronous reset; storage arrays need no reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      qcnt_q  <= '0;
      infl_q  <= '0;
      drop_q  <= '0;
      qhead_q <= '0;
      qtail_q <= '0;
      pf_rd_q <= '0;
      pf_wr_q <= '0;
    end else begin
      pc_q     <= pc_d;
      qcnt_q   <= qcnt_d;
      infl_q   <= infl_d;
      drop_q   <= drop_d;
      qhead_q  <= qhead_d;
      qtail_q  <= qtail_d;
      pf_rd_q  <= pf_rd_d;
      pf_wr_q  <= pf_wr_d;
      fq_pc_q  <= fq_pc_d;
      fq_ins_q <= fq_ins_d;
      pf_q     <= pf_d;
    end
  end

  // Credit invariants.
  a_credit : assert property (@(posedge clk) disable iff (rst)
    ({1'b0, infl_q} + {1'b0, drop_q}) <= DepthC);
  a_qcnt : assert property (@(posedge clk) disable iff (rst)
    {1'b0, qcnt_q} <= DepthC);

endmodule

// File: tb/tb_u_ifu.sv
// Randomized bench for u_ifu: a queue-based model of outstanding requests and
// fetch-queue contents predicts request issue and the instruction stream.
module tb_u_ifu;

  localparam int unsigned XLEN = 32;
  localparam int unsigned D    = 2;
  localparam logic [31:0] RPC  = 32'hFFFF_FFF8;
  localparam logic [31:0] KEY  = 32'hA5A5_0000;

  logic            clk;
  logic            rst;
  logic            hzf_ifu;
  logic            hzs_ifu;
  logic [XLEN-1:0] br_tgt;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rsp_vld;
  logic [31:0]     imem_rsp_dat;
  logic            ifu_vld;
  logic [XLEN-1:0] ifu_pc;
  logic [31:0]     ifu_ins;

  u_ifu #(
    .XLEN     (XLEN),
    .RESET_PC (RPC),
    .FQ_DEPTH (D)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .hzf_ifu      (hzf_ifu),
    .hzs_ifu      (hzs_ifu),
    .br_tgt       (br_tgt),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rsp_vld (imem_rsp_vld),
    .imem_rsp_dat (imem_rsp_dat),
    .ifu_vld      (ifu_vld),
    .ifu_pc       (ifu_pc),
    .ifu_ins      (ifu_ins)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected fetch-queue contents {pc, ins}, oldest first.
  logic [63:0] exp_q[$];
  // Requests the memory still owes: {kind, addr}; kind 0 wanted, 1 flushed, 2 pre-reset.
  logic [33:0] outst[$];
  logic [31:0] fetch_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compares the presented head against the scoreboard, pops on consume.
  always @(negedge clk) begin
    #2;
    if (rst) begin
      chk("rst_ifu_vld", {31'b0, ifu_vld}, 32'd0);
      chk("rst_ifu_pc", ifu_pc, 32'd0);
      chk("rst_ifu_ins", ifu_ins, 32'd0);
    end else begin
      chk("ifu_vld", {31'b0, ifu_vld}, {31'b0, exp_q.size() > 0});
      if (ifu_vld && exp_q.size() > 0) begin
        chk("ifu_pc", ifu_pc, exp_q[0][63:32]);
        chk("ifu_ins", ifu_ins, exp_q[0][31:0]);
        if (!hzs_ifu && !hzf_ifu) void'(exp_q.pop_front());
      end
    end
  end

  function automatic bit any_stale();
    foreach (outst[i]) if (outst[i][33:32] == 2'd2) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int count_kind(input logic [1:0] k);
    int n = 0;
    foreach (outst[i]) if (outst[i][33:32] == k) n++;
    return n;
  endfunction

  // One clock cycle: drive at negedge, check request side, then advance the model.
  task automatic cycle(input bit r, input bit f, input bit s, input int gnt_pct,
                       input int rsp_pct, input logic [31:0] tgt);
    bit mreq;
    bit rsp;
    int c0;
    int c1;
    logic [33:0] e;
    @(negedge clk);
    rst     = r;
    hzf_ifu = f;
    hzs_ifu = s;
    br_tgt  = tgt;
    // Hold off grants until pre-reset responses have come back.
    imem_gnt = !any_stale() && ($urandom_range(99) < gnt_pct);
    rsp = (outst.size() > 0) && ($urandom_range(99) < rsp_pct);
    imem_rsp_vld = rsp;
    imem_rsp_dat = rsp ? (outst[0][31:0] ^ KEY) : $urandom;
    #1;
    c0 = count_kind(2'd0);
    c1 = count_kind(2'd1);
    mreq = !r && !f && (exp_q.size() + c0 < D) && (c0 + c1 < D);
    chk("imem_req", {31'b0, imem_req}, {31'b0, mreq});
    chk("imem_addr", imem_addr, r ? RPC : fetch_pc);
    #2;
    if (rsp) e = outst.pop_front();
    if (r) begin
      foreach (outst[i]) outst[i][33:32] = 2'd2;
      exp_q.delete();
      fetch_pc = RPC;
    end else begin
      if (rsp && !f && e[33:32] == 2'd0) exp_q.push_back({e[31:0], e[31:0] ^ KEY});
      if (f) begin
        exp_q.delete();
        foreach (outst[i]) if (outst[i][33:32] == 2'd0) outst[i][33:32] = 2'd1;
        fetch_pc = {tgt[31:2], 2'b00};
      end else if (mreq && imem_gnt) begin
        outst.push_back({2'd0, fetch_pc});
        fetch_pc = fetch_pc + 32'd4;
      end
    end
  endtask

  // Run idle-fetch cycles until nothing is outstanding and the queue is empty.
  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (outst.size() == 0 && exp_q.size() == 0) break;
      cycle(1'b0, 1'b0, 1'b0, 0, 100, 32'd0);
    end
    chk("drain_done", {31'b0, outst.size() == 0 && exp_q.size() == 0}, 32'd1);
  endtask

  // Grant without responses until two requests are in flight.
  task automatic fill_two();
    for (int i = 0; i < 10; i++) begin
      if (count_kind(2'd0) >= 2) break;
      cycle(1'b0, 1'b0, 1'b0, 100, 0, 32'd0);
    end
    chk("two_inflight", count_kind(2'd0), 32'd2);
  endtask

  initial begin
    logic [31:0] t;
    rst          = 1'b1;
    hzf_ifu      = 1'b0;
    hzs_ifu      = 1'b0;
    br_tgt       = '0;
    imem_gnt     = 1'b0;
    imem_rsp_vld = 1'b0;
    imem_rsp_dat = '0;
    fetch_pc     = RPC;

    repeat (2) cycle(1'b1, 1'b0, 1'b0, 0, 0, 32'd0);
    // Streaming with immediate grants and one-cycle responses; covers the wrap.
    repeat (30) cycle(1'b0, 1'b0, 1'b0, 100, 100, 32'd0);
    // Long stall: credits run out, head held; then release.
    repeat (10) cycle(1'b0, 1'b0, 1'b1, 100, 100, 32'd0);
    chk("stall_full", exp_q.size(), D);
    repeat (10) cycle(1'b0, 1'b0, 1'b0, 100, 100, 32'd0);

    // Flush with two wanted requests in flight; old responses must be discarded.
    drain();
    fill_two();
    cycle(1'b0, 1'b1, 1'b0, 100, 0, 32'h0000_0103);
    repeat (15) cycle(1'b0, 1'b0, 1'b0, 100, 100, 32'd0);

    // Flush coinciding with a response, then flush together with stall.
    drain();
    cycle(1'b0, 1'b0, 1'b0, 100, 0, 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 0, 100, 32'h0000_0040);
    repeat (6) cycle(1'b0, 1'b0, 1'b0, 100, 100, 32'd0);
    cycle(1'b0, 1'b1, 1'b1, 100, 100, 32'h0000_0200);
    repeat (6) cycle(1'b0, 1'b0, 1'b0, 100, 100, 32'd0);

    // Reset with two in flight; their responses return after reset.
    drain();
    fill_two();
    cycle(1'b1, 1'b0, 1'b0, 0, 0, 32'd0);
    repeat (12) cycle(1'b0, 1'b0, 1'b0, 100, 100, 32'd0);

    // Random mix of grants, response latency, stalls and flushes.
    for (int i = 0; i < 600; i++) begin
      t = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
      cycle(($urandom_range(199) == 0), ($urandom_range(99) < 7), ($urandom_range(99) < 25),
            70, 60, t);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
